// File: rtl/gf_horner_bank.sv
// GF(2^M) multiply-accumulate bank. NCH channels run Horner's rule over one block of
// BLKLEN symbols (acc_i = acc_i * coef_i ^ sym) and return every channel result in one word.
module gf_horner_bank #(
  parameter int unsigned M      = 5,
  parameter logic [M:0]  PRIM   = 6'b100101,
  parameter int unsigned NCH    = 4,
  parameter int unsigned BLKLEN = 31
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [NCH*M-1:0]   coef,
  input  logic               in_valid,
  input  logic [M-1:0]       in_sym,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NCH*M-1:0]   out_data,
  output logic               busy,
  output logic [15:0]        sym_cnt
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  localparam logic [15:0] LastCnt = 16'(BLKLEN - 1);

  state_e             state_q;
  logic [NCH*M-1:0]   acc_q;
  logic [NCH*M-1:0]   coef_q;
  logic [15:0]        cnt_q;
  logic [NCH*M-1:0]   acc_mac;

  // Shift-and-add product, reducing by PRIM whenever x^M would appear.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p;
    logic [M-1:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < int'(M); i++) begin
      if (b[i]) p = p ^ t;
      t = t[M-1] ? ({t[M-2:0], 1'b0} ^ PRIM[M-1:0]) : {t[M-2:0], 1'b0};
    end
    return p;
  endfunction

  // One Horner step for every channel, using the symbol currently on in_sym.
  always_comb begin
    acc_mac = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      acc_mac[i*M +: M] = gf_mul(acc_q[i*M +: M], coef_q[i*M +: M]) ^ in_sym;
    end
  end

  // Control FSM plus accumulator, coefficient and symbol-count registers; abort overrides all.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      coef_q  <= '0;
      cnt_q   <= '0;
    end else if (abort) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            coef_q  <= coef;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= StAccum;
          end
        end
        StAccum: begin
          if (in_valid) begin
            acc_q <= acc_mac;
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q == LastCnt) state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            cnt_q <= '0;
            // Back-to-back: a start alongside the handshake skips IDLE.
            if (start) begin
              coef_q  <= coef;
              acc_q   <= '0;
              state_q <= StAccum;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_data  = acc_q;
  assign sym_cnt   = cnt_q;

endmodule

// File: tb/tb_gf_horner_bank.sv
// Bench for gf_horner_bank: four instances (BLKLEN 1, 3, 4, 6) share stimulus; results are
// checked against a log/antilog GF(32) model evaluating the block polynomial directly.
module tb_gf_horner_bank;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, abort, in_valid, out_ready;
  logic [19:0] coef;
  logic [4:0]  in_sym;

  logic        rdy [4];
  logic        ov  [4];
  logic        bsy [4];
  logic [19:0] od  [4];
  logic [15:0] cnt [4];

  int checks = 0;
  int errors = 0;
  int exp_t [31];
  int log_t [32];

  always #5 clock = ~clock;

  // Index 0: BLKLEN 1, 1: BLKLEN 3, 2: BLKLEN 4, 3: BLKLEN 6
  for (genvar g = 0; g < 4; g++) begin : g_dut
    gf_horner_bank #(
      .M(5), .PRIM(6'b100101), .NCH(4),
      .BLKLEN(g == 0 ? 1 : g == 1 ? 3 : g == 2 ? 4 : 6)
    ) u_dut (
      .clock(clock), .reset_n(reset_n), .start(start), .abort(abort), .coef(coef),
      .in_valid(in_valid), .in_sym(in_sym), .in_ready(rdy[g]), .out_valid(ov[g]),
      .out_ready(out_ready), .out_data(od[g]), .busy(bsy[g]), .sym_cnt(cnt[g])
    );
  end

  task automatic init_tables();
    int v;
    v = 1;
    for (int k = 0; k < 31; k++) begin
      exp_t[k] = v;
      log_t[v] = k;
      v = v * 2;
      if (v >= 32) v = v ^ 37;
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % 31];
  endfunction

  function automatic int gpow(input int c, input int e);
    if (e == 0) return 1;
    if (c == 0) return 0;
    return exp_t[(log_t[c] * e) % 31];
  endfunction

  // Each channel: sum over j of s[j] * c^(n-1-j), first symbol is the highest power.
  function automatic logic [19:0] ref_block(input logic [19:0] c, input logic [4:0] s [32],
                                            input int n);
    logic [19:0] r;
    int acc;
    r = '0;
    for (int ch = 0; ch < 4; ch++) begin
      acc = 0;
      for (int j = 0; j < n; j++) acc = acc ^ gmul(int'(s[j]), gpow(int'(c[ch*5 +: 5]), n - 1 - j));
      r[ch*5 +: 5] = 5'(acc);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic begin_block(input logic [19:0] c);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b1;
    coef  = c;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [4:0] s);
    in_valid = 1'b1;
    in_sym   = s;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    coef = '0; in_sym = '0;
    repeat (2) tick();
    for (int g = 0; g < 4; g++) begin
      checks++;
      if ({bsy[g], rdy[g], ov[g], od[g], cnt[g]} !== 39'd0) begin
        errors++;
        $display("FAIL reset_state dut%0d got busy=%b rdy=%b ov=%b data=%h cnt=%0d want all 0",
                 g, bsy[g], rdy[g], ov[g], od[g], cnt[g]);
      end
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_xor_block();
    logic [19:0] want;
    begin_block({4{5'h01}});
    send(5'h03); send(5'h05); send(5'h09); send(5'h11);
    want = {4{5'h03 ^ 5'h05 ^ 5'h09 ^ 5'h11}};
    checks++;
    if (ov[2] !== 1'b1 || od[2] !== want) begin
      errors++; $display("FAIL xor_block got ov=%b data=%h want ov=1 data=%h", ov[2], od[2], want);
    end
    checks++;
    if (cnt[2] !== 16'd4 || rdy[2] !== 1'b0) begin
      errors++; $display("FAIL xor_cnt got cnt=%0d rdy=%b want cnt=4 rdy=0", cnt[2], rdy[2]);
    end
    checks++;
    if (ov[0] !== 1'b1 || od[0] !== {4{5'h03}} || cnt[0] !== 16'd1) begin
      errors++; $display("FAIL blklen1 got ov=%b data=%h cnt=%0d want ov=1 data=%h cnt=1",
                         ov[0], od[0], cnt[0], {4{5'h03}});
    end
  endtask

  task automatic test_alpha_power();
    logic [4:0]  s [32];
    logic [19:0] c;
    c = {5'h0A, 5'h07, 5'h01, 5'h02};
    s[0] = 5'h01;
    for (int j = 1; j < 6; j++) s[j] = 5'h00;
    begin_block(c);
    for (int j = 0; j < 6; j++) send(s[j]);
    checks++;
    if (od[3][4:0] !== 5'h05 || od[3][9:5] !== 5'h01) begin
      errors++; $display("FAIL alpha5 got ch0=%h ch1=%h want ch0=05 ch1=01", od[3][4:0], od[3][9:5]);
    end
    checks++;
    if (od[3] !== ref_block(c, s, 6) || ov[3] !== 1'b1) begin
      errors++; $display("FAIL alpha_word got %h ov=%b want %h ov=1", od[3], ov[3], ref_block(c, s, 6));
    end
  endtask

  task automatic test_gaps();
    logic [4:0] s [3];
    s[0] = 5'h01; s[1] = 5'h00; s[2] = 5'h00;
    begin_block({4{5'h02}});
    for (int k = 0; k < 3; k++) begin
      send(s[k]);
      checks++;
      if (cnt[1] !== 16'(k + 1)) begin
        errors++; $display("FAIL gap_cnt beat %0d got %0d want %0d", k, cnt[1], k + 1);
      end
      if (k < 2) begin
        repeat (2) begin
          tick();
          checks++;
          if (cnt[1] !== 16'(k + 1) || ov[1] !== 1'b0) begin
            errors++; $display("FAIL gap_hold got cnt=%0d ov=%b want cnt=%0d ov=0", cnt[1], ov[1], k + 1);
          end
        end
      end
    end
    checks++;
    if (ov[1] !== 1'b1 || od[1] !== {4{5'h04}}) begin
      errors++; $display("FAIL gap_result got ov=%b data=%h want ov=1 data=%h", ov[1], od[1], {4{5'h04}});
    end
  endtask

  // Follows test_gaps: the BLKLEN 3 instance sits in DONE holding 04 on every channel.
  task automatic test_back_to_back();
    logic [4:0]  s [32];
    logic [19:0] c;
    out_ready = 1'b0;
    repeat (5) begin
      tick();
      checks++;
      if (ov[1] !== 1'b1 || od[1] !== {4{5'h04}} || cnt[1] !== 16'd3) begin
        errors++; $display("FAIL done_hold got ov=%b data=%h cnt=%0d want ov=1 data=%h cnt=3",
                           ov[1], od[1], cnt[1], {4{5'h04}});
      end
    end
    c = 20'($urandom);
    out_ready = 1'b1; start = 1'b1; coef = c;
    tick();
    out_ready = 1'b0; start = 1'b0;
    checks++;
    if (ov[1] !== 1'b0 || bsy[1] !== 1'b1 || rdy[1] !== 1'b1 || od[1] !== 20'd0 || cnt[1] !== 16'd0) begin
      errors++; $display("FAIL b2b_restart got ov=%b busy=%b rdy=%b data=%h cnt=%0d want 0 1 1 0 0",
                         ov[1], bsy[1], rdy[1], od[1], cnt[1]);
    end
    for (int j = 0; j < 3; j++) begin
      s[j] = 5'($urandom);
      coef = 20'($urandom);
      send(s[j]);
    end
    checks++;
    if (ov[1] !== 1'b1 || od[1] !== ref_block(c, s, 3)) begin
      errors++; $display("FAIL b2b_block got ov=%b data=%h want ov=1 data=%h", ov[1], od[1], ref_block(c, s, 3));
    end
  endtask

  task automatic test_async_reset();
    logic [19:0] want;
    begin_block({4{5'h01}});
    send(5'h03); send(5'h05);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (od[2] !== 20'd0 || rdy[2] !== 1'b0 || bsy[2] !== 1'b0 || cnt[2] !== 16'd0) begin
      errors++; $display("FAIL async_reset got data=%h rdy=%b busy=%b cnt=%0d want 0 0 0 0",
                         od[2], rdy[2], bsy[2], cnt[2]);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    begin_block({4{5'h01}});
    send(5'h03); send(5'h05); send(5'h09); send(5'h11);
    want = {4{5'h03 ^ 5'h05 ^ 5'h09 ^ 5'h11}};
    checks++;
    if (ov[2] !== 1'b1 || od[2] !== want) begin
      errors++; $display("FAIL post_reset_block got ov=%b data=%h want ov=1 data=%h", ov[2], od[2], want);
    end
  endtask

  task automatic test_abort();
    begin_block(20'($urandom));
    send(5'h1F);
    abort = 1'b1; start = 1'b1; in_valid = 1'b1; in_sym = 5'h0B;
    tick();
    abort = 1'b0; start = 1'b0; in_valid = 1'b0;
    checks++;
    if (bsy[3] !== 1'b0 || od[3] !== 20'd0 || cnt[3] !== 16'd0 || rdy[3] !== 1'b0 || ov[3] !== 1'b0) begin
      errors++; $display("FAIL abort got busy=%b data=%h cnt=%0d rdy=%b ov=%b want all 0",
                         bsy[3], od[3], cnt[3], rdy[3], ov[3]);
    end
    checks++;
    if (bsy[0] !== 1'b0 || od[0] !== 20'd0) begin
      errors++; $display("FAIL abort_done got busy=%b data=%h want busy=0 data=0", bsy[0], od[0]);
    end
  endtask

  task automatic test_random();
    logic [4:0]  s [32];
    logic [19:0] c;
    for (int b = 0; b < 20; b++) begin
      c = 20'($urandom);
      begin_block(c);
      for (int j = 0; j < 6; j++) begin
        repeat ($urandom_range(0, 2)) begin
          coef = 20'($urandom);
          tick();
        end
        s[j] = 5'($urandom);
        coef = 20'($urandom);
        send(s[j]);
      end
      checks++;
      if (ov[3] !== 1'b1 || cnt[3] !== 16'd6 || od[3] !== ref_block(c, s, 6)) begin
        errors++; $display("FAIL rand6 blk %0d got ov=%b cnt=%0d data=%h want ov=1 cnt=6 data=%h",
                           b, ov[3], cnt[3], od[3], ref_block(c, s, 6));
      end
      checks++;
      if (ov[2] !== 1'b1 || od[2] !== ref_block(c, s, 4)) begin
        errors++; $display("FAIL rand4 blk %0d got ov=%b data=%h want ov=1 data=%h",
                           b, ov[2], od[2], ref_block(c, s, 4));
      end
      repeat ($urandom_range(0, 3)) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (bsy[3] !== 1'b0 || ov[3] !== 1'b0 || cnt[3] !== 16'd0) begin
        errors++; $display("FAIL rand_release blk %0d got busy=%b ov=%b cnt=%0d want 0 0 0",
                           b, bsy[3], ov[3], cnt[3]);
      end
    end
  endtask

  initial begin
    init_tables();
    test_reset();
    test_xor_block();
    test_alpha_power();
    test_gaps();
    test_back_to_back();
    test_async_reset();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
